// File: rtl/tpo5_pkg.sv
// Shared constants and helpers for the 2-of-5 scanned display.
// Code words are weighted {7,4,2,1,0} from bit 4 down to bit 0. A legal word has exactly two 1s.
// Glyphs are active-high {a,b,c,d,e,f,g}. Output polarity is applied only at the top-level registers.
package tpo5_pkg;

  localparam int DIGIT_W = 5;
  localparam int SEG_W   = 7;

  // The ten legal 2-of-5 words. 11000 (weight sum 11) stands for zero.
  localparam logic [DIGIT_W-1:0] CODE_1 = 5'b00011;
  localparam logic [DIGIT_W-1:0] CODE_2 = 5'b00101;
  localparam logic [DIGIT_W-1:0] CODE_3 = 5'b00110;
  localparam logic [DIGIT_W-1:0] CODE_4 = 5'b01001;
  localparam logic [DIGIT_W-1:0] CODE_5 = 5'b01010;
  localparam logic [DIGIT_W-1:0] CODE_6 = 5'b01100;
  localparam logic [DIGIT_W-1:0] CODE_7 = 5'b10001;
  localparam logic [DIGIT_W-1:0] CODE_8 = 5'b10010;
  localparam logic [DIGIT_W-1:0] CODE_9 = 5'b10100;
  localparam logic [DIGIT_W-1:0] CODE_0 = 5'b11000;

  // Seven-segment glyphs, {a,b,c,d,e,f,g}, 1 = segment lit.
  localparam logic [SEG_W-1:0] GLYPH_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] GLYPH_E     = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b0000000;

  // Slot index width. It is kept at least 1 bit wide so a single-digit build still has a real register.
  function automatic int slot_width(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

  // Prescaler width. The counter runs from 0 to prescale-1.
  function automatic int cnt_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

  // Number of 1s in a 5-bit code word.
  function automatic logic [2:0] popcount5(input logic [DIGIT_W-1:0] word);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < DIGIT_W; i++) begin
      n = n + {2'b00, word[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/two_of_five_scan_display_if.sv
// Bus bundle between a code source (master) and the scanned display driver (slave).
interface two_of_five_scan_display_if
  import tpo5_pkg::*;
#(
  parameter int N_DIGITS = 4
);

  logic                         load;
  logic [DIGIT_W*N_DIGITS-1:0]  code_in;
  logic [SEG_W-1:0]             seg;
  logic [N_DIGITS-1:0]          an;
  logic                         upd_ack;
  logic [N_DIGITS-1:0]          err_digits;
  logic                         err_any;
  logic                         frame_tick;

  modport master (
    output load, code_in,
    input  seg, an, upd_ack, err_digits, err_any, frame_tick
  );

  modport slave (
    input  load, code_in,
    output seg, an, upd_ack, err_digits, err_any, frame_tick
  );

endinterface

// File: rtl/two_of_five_decoder.sv
// Combinational 2-of-5 to seven-segment decoder (active-high glyph).
// Any word without exactly two 1s is flagged invalid and shown as 'E'.
module two_of_five_decoder
  import tpo5_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic               valid,
  output logic [SEG_W-1:0]   seg
);

  // Validity comes from the popcount, and the glyph comes from a lookup of the ten legal words.
  always_comb begin
    valid = (popcount5(code) == 3'd2);
    case (code)
      CODE_0:  seg = GLYPH_0;
      CODE_1:  seg = GLYPH_1;
      CODE_2:  seg = GLYPH_2;
      CODE_3:  seg = GLYPH_3;
      CODE_4:  seg = GLYPH_4;
      CODE_5:  seg = GLYPH_5;
      CODE_6:  seg = GLYPH_6;
      CODE_7:  seg = GLYPH_7;
      CODE_8:  seg = GLYPH_8;
      CODE_9:  seg = GLYPH_9;
      default: seg = GLYPH_E;
    endcase
  end

endmodule

// File: rtl/two_of_five_scan_display.sv
// Multi-digit 2-of-5 scanned seven-segment driver.
// A load writes the shadow bank. The display bank is refreshed only at the frame boundary,
// so a scan frame never mixes old and new digits. Each slot begins with an anode dead-time
// to suppress ghosting. The seg and an outputs are registered one cycle behind the counters.
module two_of_five_scan_display
  import tpo5_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int PRESCALE       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  two_of_five_scan_display_if.slave bus
);

  localparam int SLOT_W = slot_width(N_DIGITS);
  localparam int CNT_W  = cnt_width(PRESCALE);
  localparam int BANK_W = DIGIT_W * N_DIGITS;

  localparam logic [SEG_W-1:0]    SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW  != 0) ? '1 : '0;

  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic [BANK_W-1:0]   shadow_reg, shadow_next;
  logic [BANK_W-1:0]   disp_reg, disp_next;
  logic                pending_reg, pending_next;
  logic                upd_ack_reg, upd_ack_next;
  logic [SEG_W-1:0]    seg_reg, seg_next;
  logic [N_DIGITS-1:0] an_reg, an_next;

  logic                cnt_wrap;
  logic                slot_last;
  logic                frame_end;
  logic                in_blank;
  logic [N_DIGITS-1:0] an_onehot;
  logic [N_DIGITS-1:0] dig_valid;
  logic [N_DIGITS-1:0] err_digits;
  logic [SEG_W-1:0]    dig_seg [N_DIGITS];
  logic [SEG_W-1:0]    seg_lit;
  logic [N_DIGITS-1:0] an_lit;

  assign cnt_wrap  = (cnt_reg == CNT_W'(PRESCALE - 1));
  assign slot_last = (slot_reg == SLOT_W'(N_DIGITS - 1));
  assign frame_end = cnt_wrap && slot_last;

  // The anode dead-time only exists when BLANK_CYCLES is non-zero.
  // This avoids an always-false compare when it is zero.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign in_blank = (cnt_reg < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_blank
      assign in_blank = 1'b0;
    end
  endgenerate

  // One decoder per digit. Its valid output drives the error flags,
  // and its glyph is later picked by the scan slot.
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      two_of_five_decoder u_dec (
        .code  (disp_reg[DIGIT_W*gi +: DIGIT_W]),
        .valid (dig_valid[gi]),
        .seg   (dig_seg[gi])
      );
      assign err_digits[gi] = ~dig_valid[gi];
      assign an_onehot[gi]  = (slot_reg == SLOT_W'(gi));
    end
  endgenerate

  // Prescaler and slot scan. The slot advances when cnt wraps and returns to 0 after the last digit.
  always_comb begin
    cnt_next  = cnt_wrap ? '0 : cnt_reg + CNT_W'(1);
    slot_next = slot_reg;
    if (cnt_wrap) begin
      slot_next = slot_last ? '0 : slot_reg + SLOT_W'(1);
    end
  end

  // Double-buffer control.
  // - A load outside the frame end parks the code in the shadow bank.
  // - At the frame end, a pending code (or a code loaded in that same cycle) moves to the display bank.
  always_comb begin
    shadow_next  = shadow_reg;
    disp_next    = disp_reg;
    pending_next = pending_reg;
    upd_ack_next = 1'b0;
    if (frame_end) begin
      if (bus.load) begin
        shadow_next  = bus.code_in;
        disp_next    = bus.code_in;
        pending_next = 1'b0;
        upd_ack_next = 1'b1;
      end else if (pending_reg) begin
        disp_next    = shadow_reg;
        pending_next = 1'b0;
        upd_ack_next = 1'b1;
      end
    end else if (bus.load) begin
      shadow_next  = bus.code_in;
      pending_next = 1'b1;
    end
  end

  // Output drive. The glyph of the current slot is always presented.
  // The anode is suppressed during the dead-time, and polarity is applied last.
  always_comb begin
    seg_lit  = dig_seg[slot_reg];
    an_lit   = in_blank ? '0 : an_onehot;
    seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    an_next  = (AN_ACTIVE_LOW  != 0) ? ~an_lit  : an_lit;
  end

  // Scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      slot_reg <= '0;
    end else begin
      cnt_reg  <= cnt_next;
      slot_reg <= slot_next;
    end
  end

  // Shadow and display banks, pending flag and transfer acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg  <= {N_DIGITS{CODE_0}};
      disp_reg    <= {N_DIGITS{CODE_0}};
      pending_reg <= 1'b0;
      upd_ack_reg <= 1'b0;
    end else begin
      shadow_reg  <= shadow_next;
      disp_reg    <= disp_next;
      pending_reg <= pending_next;
      upd_ack_reg <= upd_ack_next;
    end
  end

  // Registered pad drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg <= SEG_OFF;
      an_reg  <= AN_OFF;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.an         = an_reg;
  assign bus.upd_ack    = upd_ack_reg;
  assign bus.err_digits = err_digits;
  assign bus.err_any    = |err_digits;
  assign bus.frame_tick = frame_end;

endmodule

// File: tb/tb_two_of_five_scan_display.sv
// Randomised scoreboard bench for the 2-of-5 scanned display.
// The driver advances a cycle-indexed reference model and queues the expected outputs.
// A negedge monitor pops one entry per cycle and compares it with the DUT.
module tb_two_of_five_scan_display;

  localparam int N     = 4;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * P;

  typedef struct {
    int         t;
    logic [6:0] seg;
    logic [3:0] an;
    logic       ack;
    logic       ft;
    logic [3:0] err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  two_of_five_scan_display_if #(.N_DIGITS(N)) bus ();

  two_of_five_scan_display #(
    .N_DIGITS       (N),
    .PRESCALE       (P),
    .BLANK_CYCLES   (B),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  // Reference model state. m_t counts cycles since reset was released.
  bit         m_valid = 1'b0;
  int         m_t;
  logic [4:0] m_disp   [N];
  logic [4:0] m_shadow [N];
  bit         m_pending;
  logic       m_ack;
  logic [6:0] m_seg_out;
  logic [3:0] m_an_out;

  // Glyph for each decimal value, {a..g}, 1 = lit.
  logic [6:0] glyph_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Digit value from the weighting rule. Returns -1 for an invalid word.
  function automatic int digit_of(input logic [4:0] w);
    int wt [5];
    int ones;
    int sum;
    wt   = '{0, 1, 2, 4, 7};
    ones = 0;
    sum  = 0;
    for (int i = 0; i < 5; i++) begin
      if (w[i]) begin
        ones++;
        sum += wt[i];
      end
    end
    if (ones != 2) return -1;
    return (sum == 11) ? 0 : sum;
  endfunction

  function automatic logic [6:0] lit_of(input logic [4:0] w);
    int d;
    d = digit_of(w);
    return (d < 0) ? 7'b1001111 : glyph_tab[d];
  endfunction

  // Each digit is usually a legal two-hot word and sometimes an arbitrary 5-bit value.
  function automatic logic [19:0] rand_code();
    logic [19:0] c;
    logic [4:0]  w;
    int          a;
    int          b;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(3) != 0) begin
        a = $urandom_range(4);
        b = $urandom_range(4);
        while (b == a) b = $urandom_range(4);
        w    = '0;
        w[a] = 1'b1;
        w[b] = 1'b1;
      end else begin
        w = 5'($urandom);
      end
      c[5*i +: 5] = w;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_t       = 0;
    m_pending = 1'b0;
    m_ack     = 1'b0;
    m_seg_out = 7'h7F;
    m_an_out  = 4'hF;
    for (int i = 0; i < N; i++) begin
      m_disp[i]   = 5'b11000;
      m_shadow[i] = 5'b11000;
    end
  endtask

  // One clock cycle. Queue the expected outputs for this cycle, drive the inputs,
  // then advance the model past the next edge.
  task automatic step(input bit r, input bit ld, input logic [19:0] code);
    exp_t       e;
    int         slot;
    int         cnt;
    bit         fe;
    logic [3:0] one;
    @(posedge clk);
    #1;
    if (m_valid) begin
      e.t   = m_t;
      e.seg = m_seg_out;
      e.an  = m_an_out;
      e.ack = m_ack;
      e.ft  = ((m_t % FRAME) == FRAME - 1);
      for (int i = 0; i < N; i++) e.err[i] = (digit_of(m_disp[i]) < 0);
      exp_q.push_back(e);
    end
    rst          = r;
    bus.load     = ld;
    bus.code_in  = code;
    if (r) begin
      model_reset();
      m_valid = 1'b1;
    end else if (m_valid) begin
      slot      = (m_t / P) % N;
      cnt       = m_t % P;
      fe        = ((m_t % FRAME) == FRAME - 1);
      one       = 4'b0001;
      m_seg_out = ~lit_of(m_disp[slot]);
      m_an_out  = (cnt < B) ? 4'hF : ~(one << slot);
      m_ack     = 1'b0;
      if (fe && ld) begin
        for (int i = 0; i < N; i++) begin
          m_shadow[i] = code[5*i +: 5];
          m_disp[i]   = code[5*i +: 5];
        end
        m_pending = 1'b0;
        m_ack     = 1'b1;
      end else if (fe && m_pending) begin
        for (int i = 0; i < N; i++) m_disp[i] = m_shadow[i];
        m_pending = 1'b0;
        m_ack     = 1'b1;
      end else if (ld) begin
        for (int i = 0; i < N; i++) m_shadow[i] = code[5*i +: 5];
        m_pending = 1'b1;
      end
      m_t++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_code());
  endtask

  // Run idle cycles until the next driven cycle sits at frame position ph.
  task automatic goto_phase(input int ph);
    while ((m_t % FRAME) != ph) step(1'b0, 1'b0, rand_code());
  endtask

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, want);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("seg",        e.t, 32'(bus.seg),        32'(e.seg));
      chk("an",         e.t, 32'(bus.an),         32'(e.an));
      chk("upd_ack",    e.t, 32'(bus.upd_ack),    32'(e.ack));
      chk("frame_tick", e.t, 32'(bus.frame_tick), 32'(e.ft));
      chk("err_digits", e.t, 32'(bus.err_digits), 32'(e.err));
      chk("err_any",    e.t, 32'(bus.err_any),    32'(|e.err));
    end
  end

  initial begin
    bus.load    = 1'b0;
    bus.code_in = '0;

    // Reset, then a full frame of "0000".
    repeat (3) step(1'b1, 1'b0, '0);
    idle(40);

    // Mid-frame load of 4,9,3,1: applied only at the frame boundary.
    goto_phase(13);
    step(1'b0, 1'b1, {5'b01001, 5'b10100, 5'b00110, 5'b00011});
    idle(70);

    // Invalid words on digits 2 and 0.
    goto_phase(9);
    step(1'b0, 1'b1, {5'b01001, 5'b00111, 5'b00110, 5'b00000});
    idle(70);

    // Two loads in one frame: the second one wins.
    goto_phase(5);
    step(1'b0, 1'b1, {5'b10001, 5'b10001, 5'b10001, 5'b10001});
    goto_phase(20);
    step(1'b0, 1'b1, {5'b01100, 5'b01010, 5'b00101, 5'b10010});
    idle(40);

    // Load exactly on the frame-end cycle: bypass into the display bank.
    goto_phase(FRAME - 1);
    step(1'b0, 1'b1, {5'b00011, 5'b00101, 5'b01010, 5'b10001});
    idle(40);

    // Pending load discarded by a mid-frame reset.
    goto_phase(10);
    step(1'b0, 1'b1, {5'b10100, 5'b10100, 5'b10100, 5'b10100});
    idle(5);
    repeat (2) step(1'b1, 1'b0, rand_code());
    idle(70);

    // Random traffic, including occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(199) == 0) step(1'b1, 1'b0, rand_code());
      else step(1'b0, ($urandom_range(11) == 0), rand_code());
    end
    idle(3);

    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain t=%0d got=%0d want=0", m_t, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
